vga_sync_decoder: RTL and testbench

Receive-side counterpart of the display controller: takes the active-low hSync/vSync pair and a pixel-rate strobe, then recovers the pixel coordinates (hCount, vCount) and the bright window. It checks line and frame lengths against the 640x480 @ 60 Hz timing and reports lock and timing errors. It sits on the bench/debug side of the VGA outputs and drives LED or SSD status in the top level.

---
 rtl/vga_sync_decoder.sv | 167 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, the bright window and lock status from an active-low
// hSync/vSync pair, checking line and frame lengths against the expected VGA timing.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 783,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 514,
    parameter int LOCK_LINES  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_en,
    input  logic       hSync,
    input  logic       vSync,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       locked,
    output logic       frame_start,
    output logic       h_err,
    output logic       v_err,
    output logic [7:0] frame_cnt
);

    localparam int GW = $clog2(LOCK_LINES + 1);
    localparam logic [GW-1:0] LOCK_MAX = GW'(LOCK_LINES);
    localparam logic [10:0] H_LEN = 11'(H_TOTAL);
    localparam logic [10:0] V_LEN = 11'(V_TOTAL);
    localparam logic [9:0]  HA_S  = 10'(H_ACT_START);
    localparam logic [9:0]  HA_E  = 10'(H_ACT_END);
    localparam logic [9:0]  VA_S  = 10'(V_ACT_START);
    localparam logic [9:0]  VA_E  = 10'(V_ACT_END);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t state, state_next;
    logic [GW-1:0] good_lines, good_next;
    logic [1:0] h_pipe, v_pipe;
    logic hs_q, vs_q;
    logic h_fall, v_fall, line_ok, frame_ok, sat_loss, in_window;
    logic h_err_next, v_err_next, fs_next;
    logic [9:0] h_next, v_next;

    assign h_fall   = pix_en && !h_pipe[1] && hs_q;
    assign v_fall   = pix_en && !v_pipe[1] && vs_q;
    assign line_ok  = ({1'b0, hCount} + 11'd1) == H_LEN;
    assign frame_ok = ({1'b0, vCount} + 11'd1) == V_LEN;
    // Losing hSync is detected as the counter arriving at (or sitting at) saturation.
    assign sat_loss = pix_en && !h_fall && (hCount >= 10'd1022);

    always_comb begin
        h_next = hCount;
        v_next = vCount;
        if (h_fall) begin
            h_next = 10'd0;
        end else if (hCount != 10'd1023) begin
            h_next = hCount + 10'd1;
        end
        if (v_fall) begin
            v_next = 10'd0;
        end else if (h_fall && vCount != 10'd1023) begin
            v_next = vCount + 10'd1;
        end
    end

    assign in_window = (h_next >= HA_S) && (h_next <= HA_E) &&
                       (v_next >= VA_S) && (v_next <= VA_E);

    always_comb begin
        state_next = state;
        good_next  = good_lines;
        h_err_next = 1'b0;
        v_err_next = 1'b0;
        fs_next    = 1'b0;
        if (pix_en) begin
            case (state)
                UNLOCKED: begin
                    if (h_fall) begin
                        state_next = ACQUIRE;
                        good_next  = '0;
                    end
                end
                ACQUIRE: begin
                    if (h_fall && line_ok && good_lines < LOCK_MAX) begin
                        good_next = good_lines + 1'b1;
                    end else if (h_fall && !line_ok) begin
                        h_err_next = 1'b1;
                        good_next  = '0;
                    end
                    if (v_fall && good_lines == LOCK_MAX && !h_err_next) begin
                        state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    h_err_next = h_fall && !line_ok;
                    v_err_next = v_fall && !frame_ok;
                    if (h_err_next || v_err_next) begin
                        state_next = ACQUIRE;
                        good_next  = '0;
                    end else begin
                        fs_next = v_fall;
                    end
                end
                default: state_next = UNLOCKED;
            endcase
            if (sat_loss) begin
                state_next = UNLOCKED;
                good_next  = '0;
                h_err_next = 1'b0;
                v_err_next = 1'b0;
                fs_next    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= UNLOCKED;
            good_lines <= '0;
        end else if (pix_en) begin
            state      <= state_next;
            good_lines <= good_next;
        end
    end

    // Synchronizers idle high so a release from reset never looks like a sync edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_pipe      <= 2'b11;
            v_pipe      <= 2'b11;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            hCount      <= '0;
            vCount      <= '0;
            bright      <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            h_pipe      <= {h_pipe[0], hSync};
            v_pipe      <= {v_pipe[0], vSync};
            h_err       <= h_err_next;
            v_err       <= v_err_next;
            frame_start <= fs_next;
            if (pix_en) begin
                hs_q   <= h_pipe[1];
                vs_q   <= v_pipe[1];
                hCount <= h_next;
                vCount <= v_next;
                bright <= (state_next == LOCKED) && in_window;
                if (fs_next) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down 12x6 raster so whole
// frames (including a 256-frame counter wrap) stay short.
module tb_vga_sync_decoder;

    localparam int H_TOT = 12;
    localparam int V_TOT = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pix_en = 1'b0;
    logic       hSync = 1'b1;
    logic       vSync = 1'b1;
    logic [9:0] hCount, vCount;
    logic       bright, locked, frame_start, h_err, v_err;
    logic [7:0] frame_cnt;

    int vectors = 0;
    int miscompares = 0;
    int pix_div = 4;
    int herr_pulses = 0, verr_pulses = 0, fs_pulses = 0, stray_pulses = 0;
    logic pix_en_q = 1'b0;

    logic [9:0] obs_h, obs_v, v_at_start, v_at_first;
    logic       obs_bright, obs_locked, locked_pre, locked_first, lk_a, lk_b;
    int         bright_in_frame, offset_errs;

    vga_sync_decoder #(
        .H_TOTAL(H_TOT), .V_TOTAL(V_TOT), .H_ACT_START(3), .H_ACT_END(10),
        .V_ACT_START(1), .V_ACT_END(4), .LOCK_LINES(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .hSync(hSync), .vSync(vSync),
        .hCount(hCount), .vCount(vCount), .bright(bright), .locked(locked),
        .frame_start(frame_start), .h_err(h_err), .v_err(v_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pix_en_q <= pix_en;

    // Pulses are one clock wide, so counting them on every falling edge counts events.
    always @(negedge clk) begin
        if (h_err) herr_pulses++;
        if (v_err) verr_pulses++;
        if (frame_start) fs_pulses++;
        if ((h_err || v_err || frame_start) && !pix_en_q) stray_pulses++;
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One source pixel: syncs change together with a pix_en strobe, outputs sampled a half clock later.
    task automatic applyStimulus(input logic hs, input logic vs);
        hSync  = hs;
        vSync  = vs;
        pix_en = 1'b1;
        @(negedge clk);
        obs_h      = hCount;
        obs_v      = vCount;
        obs_bright = bright;
        obs_locked = locked;
        pix_en     = 1'b0;
        repeat (pix_div - 1) @(negedge clk);
    endtask

    task automatic send_line(input int v, input int len);
        for (int h = 0; h < len; h++) begin
            applyStimulus((h >= 2), (v >= 2));
            if (obs_bright) bright_in_frame++;
            if (v == 0 && h == 0) begin locked_pre = obs_locked; v_at_start = obs_v; end
            if (v == 0 && h == 1) begin locked_first = obs_locked; v_at_first = obs_v; end
            if (v == 4 && h == 0) lk_a = obs_locked;
            if (v == 4 && h == 1) lk_b = obs_locked;
            if (h >= 1 && (obs_h != 10'(h - 1) || obs_v != 10'(v))) offset_errs++;
        end
    endtask

    task automatic send_frame(input int nlines, input int short_line);
        bright_in_frame = 0;
        offset_errs     = 0;
        for (int v = 0; v < nlines; v++) begin
            send_line(v, (v == short_line) ? H_TOT - 1 : H_TOT);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) applyStimulus((i % 3) != 0, (i % 5) != 0);
        checkOutput("rst_hCount", int'(hCount), 0);
        checkOutput("rst_vCount", int'(vCount), 0);
        checkOutput("rst_locked", int'(locked), 0);
        checkOutput("rst_bright", int'(bright), 0);
        checkOutput("rst_frame_cnt", int'(frame_cnt), 0);
        checkOutput("rst_pulses", herr_pulses + verr_pulses + fs_pulses, 0);

        reset_n = 1'b1;
        repeat (3) applyStimulus(1'b1, 1'b1);

        send_frame(V_TOT, -1);
        checkOutput("acq_no_herr", herr_pulses, 0);
        checkOutput("f0_locked", int'(obs_locked), 0);
        checkOutput("f0_bright", bright_in_frame, 0);

        send_frame(V_TOT, -1);
        checkOutput("f1_pre_lock", int'(locked_pre), 0);
        checkOutput("f1_lock_rise", int'(locked_first), 1);
        checkOutput("f1_no_fs", fs_pulses, 0);
        checkOutput("f1_bright_px", bright_in_frame, 32);
        checkOutput("f1_offset", offset_errs, 0);

        send_frame(V_TOT, -1);
        checkOutput("f2_fs", fs_pulses, 1);
        checkOutput("f2_frame_cnt", int'(frame_cnt), 1);
        checkOutput("simul_fall_v0", int'(v_at_first), 0);
        checkOutput("v_before_fall", int'(v_at_start), 5);

        send_frame(V_TOT, -1);
        send_frame(V_TOT, -1);
        checkOutput("f4_frame_cnt", int'(frame_cnt), 3);
        checkOutput("f4_bright_px", bright_in_frame, 32);
        checkOutput("f4_offset", offset_errs, 0);

        send_frame(V_TOT, 3);
        checkOutput("glitch_herr", herr_pulses, 1);
        checkOutput("glitch_lock_before", int'(lk_a), 1);
        checkOutput("glitch_lock_drop", int'(lk_b), 0);
        checkOutput("glitch_frame_cnt", int'(frame_cnt), 4);

        send_frame(V_TOT, -1);
        checkOutput("f6_unlocked", int'(locked_first), 0);
        send_frame(V_TOT, -1);
        checkOutput("f7_relock", int'(locked_first), 1);
        checkOutput("f7_frame_cnt", int'(frame_cnt), 4);
        send_frame(V_TOT, -1);
        checkOutput("f8_frame_cnt", int'(frame_cnt), 5);

        send_frame(V_TOT - 1, -1);
        checkOutput("f9_frame_cnt", int'(frame_cnt), 6);
        send_frame(V_TOT, -1);
        checkOutput("ferr_verr", verr_pulses, 1);
        checkOutput("ferr_locked", int'(locked_first), 0);
        checkOutput("ferr_frame_cnt", int'(frame_cnt), 6);
        send_frame(V_TOT, -1);
        checkOutput("f11_relock", int'(locked_first), 1);
        send_frame(V_TOT, -1);
        checkOutput("f12_frame_cnt", int'(frame_cnt), 7);

        repeat (1100) applyStimulus(1'b1, 1'b1);
        checkOutput("loss_hCount", int'(hCount), 1023);
        checkOutput("loss_vCount", int'(vCount), 5);
        checkOutput("loss_locked", int'(locked), 0);
        checkOutput("loss_bright", int'(bright), 0);
        checkOutput("loss_no_herr", herr_pulses, 1);
        checkOutput("loss_no_verr", verr_pulses, 1);

        send_frame(V_TOT, -1);
        checkOutput("resume_no_herr", herr_pulses, 1);
        checkOutput("resume_locked", int'(obs_locked), 0);
        send_frame(V_TOT, -1);
        checkOutput("f14_lock", int'(locked_first), 1);
        send_frame(V_TOT, -1);
        checkOutput("f15_frame_cnt", int'(frame_cnt), 8);

        pix_div = 2;
        for (int f = 0; f < 256; f++) send_frame(V_TOT, -1);
        checkOutput("wrap_frame_cnt", int'(frame_cnt), 8);
        checkOutput("wrap_fs_pulses", fs_pulses, 264);
        checkOutput("wrap_herr", herr_pulses, 1);
        checkOutput("wrap_verr", verr_pulses, 1);
        checkOutput("stray_pulses", stray_pulses, 0);

        for (int v = 0; v < 3; v++) send_line(v, H_TOT);
        reset_n = 1'b0;
        send_line(3, H_TOT);
        send_line(4, H_TOT);
        checkOutput("midrst_hCount", int'(hCount), 0);
        checkOutput("midrst_vCount", int'(vCount), 0);
        checkOutput("midrst_locked", int'(locked), 0);
        checkOutput("midrst_bright", int'(bright), 0);
        checkOutput("midrst_frame_cnt", int'(frame_cnt), 0);
        reset_n = 1'b1;
        send_line(5, H_TOT);
        send_frame(V_TOT, -1);
        checkOutput("postrst_no_herr", herr_pulses, 1);
        checkOutput("postrst_locked", int'(locked), 0);
        checkOutput("postrst_frame_cnt", int'(frame_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
